load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the word-wide data memory port: accepts one load or store request at a time from the execute stage and drives the memory's `addr`/`we`/`wd` inputs, sampling its combinational `dataOut`. Handles RV32I byte, halfword and word widths. Sub-word stores are performed as read-modify-write because the memory writes only whole words. Returns sign- or zero-extended load data and flags misaligned, out-of-range and illegal-width requests.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words in the attached memory; word index must be < MEM_WORDS.
- `clk` in 1: clock; memory writes on the same rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; request accepted on `req_valid && req_ready` at a rising edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code (load 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store 0 SB, 1 SH, 2 SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected; valid with `resp_valid`.
- `mem_addr` out 32: word index, `req_addr >> 2`.
- `mem_we` out 1: memory write enable.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory `dataOut`; combinational in `mem_addr`.

## Operation
- **States**
  - IDLE: `req_ready=1`.
  - ACCESS: memory read, or SW write.
  - WRITE: sub-word merged write.
  - RESP: `resp_valid=1`.
- **Accept (IDLE)**
  - Latch `req_write`, `funct3`, `addr`, `wdata`.
  - Check the request:
    - misaligned: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`;
    - out of range: `addr>>2 >= MEM_WORDS`;
    - illegal width: load funct3 of 3, 6 or 7; store funct3 > 2.
  - Any check fails -> RESP with `resp_err=1`; no memory access, `mem_we` is never asserted.
  - Otherwise -> ACCESS.
- **ACCESS**
  - `mem_addr` = word index.
  - Load: capture `mem_rd` at the end of the cycle, then -> RESP.
  - SW: `mem_we=1`, `mem_wd=wdata`, then -> RESP.
  - SB/SH: capture `mem_rd`, `mem_we=0`, then -> WRITE.
- **WRITE**
  - `mem_we=1`.
  - `mem_wd` = captured word with the addressed lane replaced:
    - byte k = `addr[1:0]` occupies bits `[8k+7:8k]`;
    - halfword at `addr[1]` occupies bits `[16h+15:16h]`.
  - Then -> RESP.
- **Lanes and extension**
  - Little-endian lane selection.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **RESP**
  - `resp_valid=1` for exactly one cycle; there is no response back-pressure.
  - Then -> IDLE.
- `mem_we` is 0 in every state except SW-ACCESS and WRITE.
- `mem_addr` and `mem_wd` hold their last values when unused.

## Timing
- **Reset (asynchronous)**
  - State -> IDLE; all internal registers cleared.
  - `req_ready=0` while `reset` is high, 1 on the first cycle after release.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`.
- **Reset mid-operation**
  - The request is dropped and no response is issued.
  - `mem_we` falls immediately, so no write occurs at the next edge.
  - A sub-word store aborted in ACCESS leaves memory unchanged.
- **Latency**, accept edge to `resp_valid` high:
  - loads and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- **Back-to-back**
  - `req_ready` returns high the cycle after RESP.
  - The next accept is possible at the edge ending that cycle.
- `req_*` inputs are ignored whenever `req_ready=0`.
- **Read-after-write**: a load issued right after a store completes observes the stored value, because the write commits before RESP.

## Test plan
- **LW**
  - Stimulus: preload word 1 = 32'h80FF7F01; LW at byte 0x4.
  - Required: `resp_rdata=32'h80FF7F01` and `resp_err=0`, exactly 2 cycles after accept.
- **Sub-word loads**, same word:
  - LB 0x6 -> 32'hFFFFFFFF;
  - LBU 0x6 -> 32'h000000FF;
  - LH 0x6 -> 32'hFFFF80FF;
  - LHU 0x4 -> 32'h00007F01.
- **Sub-word stores**
  - Stimulus: word 2 = 32'hCCDBEABF; SB 0x9 with wdata 32'h000000AA, then SH 0xA with wdata 32'h00001234.
  - Required: memory word 2 = 32'h1234AABF; exactly one `mem_we` cycle per store; 3-cycle latency each.
- **Errors**
  - Requests:
    - LW 0x2;
    - SH 0x5;
    - LW at byte 0x400 (word 256);
    - load with funct3 3.
  - Required for each: `resp_err=1`, `resp_rdata=0`, 1-cycle latency, `mem_we` never asserted.
- **Reset mid-store**
  - Stimulus: SB 0x3FC, wdata 32'hBE, with word 255 = 32'hCAFEBABE; assert `reset` during ACCESS.
  - Required:
    - `mem_we` stays 0;
    - word 255 is unchanged;
    - no `resp_valid`;
    - `req_ready=1` on the cycle after release.
- **Back-to-back**
  - Stimulus: SW 0xC with wdata 32'hDEADBEEF immediately followed by LW 0xC.
  - Required: load returns 32'hDEADBEEF; the second accept falls on the cycle after the first RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide, combinational-read data memory.
// Sub-word stores are read-modify-write; bad requests are answered with resp_err.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        wr;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [15:0] wdata;

  logic illegal, misaligned, oor, req_bad;

  always_comb begin
    illegal    = req_write ? (req_funct3 > 3'd2)
                           : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    oor        = {2'b00, req_addr[31:2]} >= MEM_WORDS[31:0];
    req_bad    = illegal | misaligned | oor;
  end

  // Held low during reset so nothing is accepted until the unit is out of reset.
  assign req_ready = (state == IDLE) && !reset;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] fn,
                                           input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (fn)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd2:    load_ext = w;
      3'd4:    load_ext = {24'h0, b};
      3'd5:    load_ext = {16'h0, h};
      default: load_ext = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic half,
                                        input logic [1:0] o, input logic [15:0] d);
    merge = w;
    if (half) merge[{o[1], 4'b0000} +: 16] = d;
    else      merge[{o, 3'b000} +: 8]      = d[7:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr         <= 1'b0;
      f3         <= 3'd0;
      off        <= 2'd0;
      wdata      <= 16'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wd     <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr    <= req_write;
          f3    <= req_funct3;
          off   <= req_addr[1:0];
          wdata <= req_wdata[15:0];
          if (req_bad) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
            state      <= RESP;
          end else begin
            mem_addr <= {2'b00, req_addr[31:2]};
            // A full-word store commits during ACCESS; no read needed.
            if (req_write && req_funct3 == 3'd2) begin
              mem_we <= 1'b1;
              mem_wd <= req_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (!wr) begin
            resp_rdata <= load_ext(mem_rd, f3, off);
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (f3 == 3'd2) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_we <= 1'b1;
            mem_wd <= merge(mem_rd, f3[0], off, wdata);
            state  <= WRITE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized checks of load_store_unit against a word-array memory
// and an arithmetic reference of RV32I load/store semantics.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          we_cnt;
  int          vecs;
  int          errs;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive at a falling edge, accept at the next rising edge,
  // then count cycles until resp_valid is seen (0 = never seen).
  task automatic do_req(input logic w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat, output int wes);
    int we0;
    @(negedge clk);
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_funct3 = fn; req_addr = a; req_wdata = d;
    we0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = 32'h0; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; e = resp_err;
        break;
      end
    end
    wes = we_cnt - we0;
  endtask

  task automatic directed(input string tag, input logic w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
    logic [31:0] rd; logic e; int lat, wes;
    do_req(w, fn, a, d, rd, e, lat, wes);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'h0, e}, {31'h0, exp_e});
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_we"}, wes, (w && !exp_e) ? 1 : 0);
  endtask

  // Reference: expectations computed from the ISA rules on a word array.
  task automatic run_op(input logic w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] rd, word, exp_rd, cur;
    logic        e, bad;
    int          lat, wes, o, exp_lat;
    logic [7:0]  b;
    logic [15:0] h;
    word = a >> 2;
    o    = int'(a % 4);
    bad  = (w ? (fn > 3'd2) : (fn == 3 || fn == 6 || fn == 7)) ||
           ((fn % 4) == 1 && (o % 2) != 0) || ((fn % 4) == 2 && o != 0) ||
           (word >= 256);
    exp_rd = 32'h0;
    if (bad)         exp_lat = 1;
    else if (w && fn != 3'd2) exp_lat = 3;
    else             exp_lat = 2;
    if (!bad) begin
      cur = ref_mem[word];
      b = 8'((cur >> (8 * o)) % 256);
      h = 16'((cur >> (16 * (o / 2))) % 65536);
      if (!w) begin
        case (fn)
          3'd0: exp_rd = 32'($signed(b));
          3'd1: exp_rd = 32'($signed(h));
          3'd2: exp_rd = cur;
          3'd4: exp_rd = 32'(b);
          default: exp_rd = 32'(h);
        endcase
      end else if (fn == 3'd0) cur[8*o +: 8] = d[7:0];
      else if (fn == 3'd1)     cur[16*(o/2) +: 16] = d[15:0];
      else                     cur = d;
      if (w) ref_mem[word] = cur;
    end
    do_req(w, fn, a, d, rd, e, lat, wes);
    chk("rnd_rdata", rd, exp_rd);
    chk("rnd_err", {31'h0, e}, {31'h0, bad});
    chk("rnd_lat", lat, exp_lat);
    chk("rnd_we", wes, (w && !bad) ? 1 : 0);
  endtask

  initial begin
    logic [31:0] d, addr;
    logic        w;
    logic [2:0]  fn;
    int          we0;
    vecs = 0; errs = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // Loads of every width from one word
    directed("sw_pre1", 1, 3'd2, 32'h4, 32'h80FF7F01, 32'h0, 0, 2);
    directed("lw",      0, 3'd2, 32'h4, 32'h0, 32'h80FF7F01, 0, 2);
    directed("lb",      0, 3'd0, 32'h6, 32'h0, 32'hFFFFFFFF, 0, 2);
    directed("lbu",     0, 3'd4, 32'h6, 32'h0, 32'h000000FF, 0, 2);
    directed("lh",      0, 3'd1, 32'h6, 32'h0, 32'hFFFF80FF, 0, 2);
    directed("lhu",     0, 3'd5, 32'h4, 32'h0, 32'h00007F01, 0, 2);

    // Read-modify-write sub-word stores
    directed("sw_pre2", 1, 3'd2, 32'h8, 32'hCCDBEABF, 32'h0, 0, 2);
    directed("sb",      1, 3'd0, 32'h9, 32'h000000AA, 32'h0, 0, 3);
    directed("sh",      1, 3'd1, 32'hA, 32'h00001234, 32'h0, 0, 3);
    chk("mem_word2", mem[2], 32'h1234AABF);

    // Rejected requests
    directed("err_lw_mis", 0, 3'd2, 32'h2,   32'h0, 32'h0, 1, 1);
    directed("err_sh_mis", 1, 3'd1, 32'h5,   32'hFFFF, 32'h0, 1, 1);
    directed("err_range",  0, 3'd2, 32'h400, 32'h0, 32'h0, 1, 1);
    directed("err_f3",     0, 3'd3, 32'h0,   32'h0, 32'h0, 1, 1);
    directed("err_sw_f3",  1, 3'd4, 32'h0,   32'h0, 32'h0, 1, 1);

    // Reset during the read phase of a byte store
    directed("sw_pre255", 1, 3'd2, 32'h3FC, 32'hCAFEBABE, 32'h0, 0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h3FC; req_wdata = 32'hBE;
    we0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_access_we", {31'h0, mem_we}, 32'h0);
    reset = 1'b1;
    #1;
    chk("abort_ready_in_rst", {31'h0, req_ready}, 32'h0);
    chk("abort_we_in_rst", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    chk("abort_no_write", we_cnt - we0, 32'h0);
    chk("abort_word255", mem[255], 32'hCAFEBABE);

    // Back-to-back store then load; do_req's first falling edge is the idle
    // cycle right after RESP, so acceptance lands on the edge ending it.
    directed("b2b_sw", 1, 3'd2, 32'hC, 32'hDEADBEEF, 32'h0, 0, 2);
    directed("b2b_lw", 0, 3'd2, 32'hC, 32'h0, 32'hDEADBEEF, 0, 2);

    // Randomized traffic over words 0..15 plus occasional out-of-range words
    for (int i = 0; i < 16; i++) run_op(1'b1, 3'd2, 32'(i * 4), $urandom);
    for (int i = 0; i < 120; i++) begin
      w    = 1'($urandom);
      fn   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) == 0) ? 32'(256 + $urandom_range(0, 40))
                                         : 32'($urandom_range(0, 15));
      addr = (addr << 2) | 32'($urandom_range(0, 3));
      d    = $urandom;
      run_op(w, fn, addr, d);
    end
    for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
